// File: rtl/seg_counter_pkg.sv
// Shared types and constants for the BCD counter / seven-segment scan slice.
package seg_counter_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [6:0] seg_pattern_t;

  localparam seg_pattern_t SEG_BLANK = 7'h00;
  localparam seg_pattern_t SEG_ZERO  = 7'h3F;
  localparam bcd_digit_t   BCD_ZERO  = 4'd0;
  localparam bcd_digit_t   BCD_NINE  = 4'd9;

  // Non-decimal codes are forced to zero so the counter never leaves the BCD range.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
    bcd_digit_t r;
    if (d > BCD_NINE) r = BCD_ZERO;
    else              r = d;
    return r;
  endfunction

endpackage

// File: rtl/seg7.sv
// Seven-segment decoder, active-high {g,f,e,d,c,b,a}; non-decimal codes are blanked.
module seg7
  import seg_counter_pkg::*;
(
  input  logic [3:0] count,
  output logic [6:0] segments
);

  // Digit-to-pattern lookup.
  always_comb begin
    case (count)
      4'd0:    segments = SEG_ZERO;
      4'd1:    segments = 7'h06;
      4'd2:    segments = 7'h5B;
      4'd3:    segments = 7'h4F;
      4'd4:    segments = 7'h66;
      4'd5:    segments = 7'h6D;
      4'd6:    segments = 7'h7D;
      4'd7:    segments = 7'h07;
      4'd8:    segments = 7'h7F;
      4'd9:    segments = 7'h6F;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with tick prescaler and multiplexed 7-segment scan.
// Define SEG_COUNTER_LZB_EN to blank leading zeros on the display.
module bcd_scan_counter
  import seg_counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1000,
  parameter int SCAN_DIV = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  carry,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SCAN_ONE  = SW'(1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [DIGITS-1:0] SEL_ONE = DIGITS'(1);

  logic [4*DIGITS-1:0] bcd_r;
  logic                carry_r;
  logic [PW-1:0]       presc_r;
  logic [SW-1:0]       scan_r;
  logic [IW-1:0]       idx_r;
  logic [DIGITS-1:0]   sel_r;
  seg_pattern_t        seg_r;

  logic                tick_s;
  logic                wrap_s;
  logic [DIGITS-1:0]   roll_s;
  logic [DIGITS-1:0]   step_s;
  logic [4*DIGITS-1:0] cnt_next_s;
  bcd_digit_t          nxt_dig_s [DIGITS];
  logic [PW-1:0]       presc_next_s;
  logic [SW-1:0]       scan_next_s;
  logic [IW-1:0]       idx_next_s;
  logic [DIGITS-1:0]   sel_next_s;
  bcd_digit_t          scan_dig_s;
  seg_pattern_t        seg_dec_s;
  seg_pattern_t        seg_next_s;

  assign tick_s = en & (presc_r == PRESC_MAX);
  // A full ripple through every digit is the wrap condition.
  assign wrap_s = tick_s & (&roll_s);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_t cur_s;
    bcd_digit_t cnt_s;

    assign cur_s     = bcd_r[4*g +: 4];
    assign roll_s[g] = up ? (cur_s == BCD_NINE) : (cur_s == BCD_ZERO);
    // Digit g steps when every lower digit rolls over; computed flat to avoid a comb chain.
    assign step_s[g] = tick_s & (&(roll_s | ~((SEL_ONE << g) - SEL_ONE)));

    // Per-digit increment/decrement with roll-over.
    always_comb begin
      cnt_s = cur_s;
      if (!step_s[g])      cnt_s = cur_s;
      else if (roll_s[g])  cnt_s = up ? BCD_ZERO : BCD_NINE;
      else if (up)         cnt_s = cur_s + 4'd1;
      else                 cnt_s = cur_s - 4'd1;
    end

    assign nxt_dig_s[g]         = load ? bcd_sanitize(load_val[4*g +: 4]) : cnt_s;
    assign cnt_next_s[4*g +: 4] = nxt_dig_s[g];
  end

  // Prescaler next state; load restarts the tick interval.
  always_comb begin
    presc_next_s = presc_r;
    if (load)                      presc_next_s = '0;
    else if (!en)                  presc_next_s = presc_r;
    else if (presc_r == PRESC_MAX) presc_next_s = '0;
    else                           presc_next_s = presc_r + PRESC_ONE;
  end

  // Free-running scan timer and digit index.
  always_comb begin
    scan_next_s = scan_r;
    idx_next_s  = idx_r;
    if (scan_r == SCAN_MAX) begin
      scan_next_s = '0;
      if (idx_r == IDX_MAX) idx_next_s = '0;
      else                  idx_next_s = idx_r + IDX_ONE;
    end else begin
      scan_next_s = scan_r + SCAN_ONE;
      idx_next_s  = idx_r;
    end
  end

  // One-hot select and digit mux follow the next index so both outputs move together.
  always_comb begin
    sel_next_s = '0;
    scan_dig_s = BCD_ZERO;
    for (int i = 0; i < DIGITS; i++) begin
      sel_next_s[i] = (idx_next_s == IW'(i));
      scan_dig_s    = (idx_next_s == IW'(i)) ? nxt_dig_s[i] : scan_dig_s;
    end
  end

  seg7 u_seg7 (
    .count    (scan_dig_s),
    .segments (seg_dec_s)
  );

`ifdef SEG_COUNTER_LZB_EN
  logic [DIGITS-1:0] zero_s;
  logic              blank_s;

  for (genvar z = 0; z < DIGITS; z++) begin : g_zero
    assign zero_s[z] = (nxt_dig_s[z] == BCD_ZERO);
  end

  // Blank when the shown digit and all digits above it are zero, never digit 0.
  always_comb begin
    blank_s = 1'b0;
    if (idx_next_s != '0) blank_s = &(zero_s | ((SEL_ONE << idx_next_s) - SEL_ONE));
    else                  blank_s = 1'b0;
    seg_next_s = blank_s ? SEG_BLANK : seg_dec_s;
  end
`else
  assign seg_next_s = seg_dec_s;
`endif

  // All state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd_r   <= '0;
      carry_r <= 1'b0;
      presc_r <= '0;
      scan_r  <= '0;
      idx_r   <= '0;
      sel_r   <= SEL_ONE;
      seg_r   <= SEG_ZERO;
    end else begin
      bcd_r   <= cnt_next_s;
      carry_r <= ~load & wrap_s;
      presc_r <= presc_next_s;
      scan_r  <= scan_next_s;
      idx_r   <= idx_next_s;
      sel_r   <= sel_next_s;
      seg_r   <= seg_next_s;
    end
  end

  assign bcd_out   = bcd_r;
  assign carry     = carry_r;
  assign segments  = seg_r;
  assign digit_sel = sel_r;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed scoreboard bench for bcd_scan_counter (DIGITS=4, TICK_DIV=4, SCAN_DIV=2).
module tb_bcd_scan_counter;

  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] bcd_out;
  logic        carry;
  logic [6:0]  segments;
  logic [3:0]  digit_sel;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bcd_scan_counter #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_val  (load_val),
    .bcd_out   (bcd_out),
    .carry     (carry),
    .segments  (segments),
    .digit_sel (digit_sel)
  );

  function automatic logic [6:0] seg_model(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL sb_underflow: observed %0h expected <none>", obs);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    load_val = v;
    cyc(1);
    load     = 1'b0;
  endtask

  initial begin
    int          idx;
    logic [15:0] shown;
    logic [6:0]  exp_seg;

    reset_n  = 1'b0;
    en       = 1'b0;
    up       = 1'b1;
    load     = 1'b0;
    load_val = 16'h0000;
    cyc(2);

    // 1: reset release
    reset_n = 1'b1;
    push("rst_bcd", 32'h0000); push("rst_carry", 32'h0);
    push("rst_sel", 32'h1);    push("rst_seg", 32'h3F);
    cyc(1);
    pop_chk(bcd_out); pop_chk(carry); pop_chk(digit_sel); pop_chk(segments);

    // 2: count up 20 enabled cycles, then hold
    en = 1'b1;
    up = 1'b1;
    push("count20", 32'h0005);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("carry_idle", carry, 32'h0);
    end
    pop_chk(bcd_out);
    en = 1'b0;
    push("hold_en0", 32'h0005);
    cyc(10);
    pop_chk(bcd_out);

    // 3: up wrap and multi-digit carry
    push("load_9999", 32'h9999);
    do_load(16'h9999);
    pop_chk(bcd_out);
    en = 1'b1;
    push("pre_wrap_bcd", 32'h9999); push("pre_wrap_carry", 32'h0);
    cyc(3);
    pop_chk(bcd_out); pop_chk(carry);
    push("wrap_bcd", 32'h0000); push("wrap_carry", 32'h1); push("carry_1cyc", 32'h0);
    cyc(1);
    pop_chk(bcd_out); pop_chk(carry);
    cyc(1);
    pop_chk(carry);
    push("up_0199", 32'h0200);
    do_load(16'h0199);
    cyc(4);
    pop_chk(bcd_out);

    // 4: count down, borrow and down wrap
    up = 1'b0;
    push("dn_0100", 32'h0099);
    do_load(16'h0100);
    cyc(4);
    pop_chk(bcd_out);
    push("dn_wrap_bcd", 32'h9999); push("dn_wrap_carry", 32'h1);
    do_load(16'h0000);
    cyc(4);
    pop_chk(bcd_out); pop_chk(carry);

    // 5: load sanitising, load beats tick, async reset
    up = 1'b1;
    push("load_12A4", 32'h1204);
    do_load(16'h12A4);
    pop_chk(bcd_out);
    push("pre_tick", 32'h1204);
    cyc(3);
    pop_chk(bcd_out);
    push("load_in_tick_bcd", 32'h3456); push("load_in_tick_carry", 32'h0);
    do_load(16'h3456);
    pop_chk(bcd_out); pop_chk(carry);
    push("presc_cleared", 32'h3456); push("tick_after_load", 32'h3457);
    cyc(3);
    pop_chk(bcd_out);
    cyc(1);
    pop_chk(bcd_out);

    push("async_bcd", 32'h0000); push("async_carry", 32'h0);
    push("async_sel", 32'h1);    push("async_seg", 32'h3F);
    #2 reset_n = 1'b0;
    #1;
    pop_chk(bcd_out); pop_chk(carry); pop_chk(digit_sel); pop_chk(segments);
    @(negedge clk);
    reset_n = 1'b1;
    push("first_after_rst0", 32'h0000); push("first_after_rst1", 32'h0001);
    cyc(3);
    pop_chk(bcd_out);
    cyc(1);
    pop_chk(bcd_out);

    // 6: scan frame with 0042 loaded straight out of reset
    #2 reset_n = 1'b0;
    en       = 1'b0;
    load     = 1'b1;
    load_val = 16'h0042;
    @(negedge clk);
    reset_n = 1'b1;
    shown = 16'h0042;
    for (int i = 0; i < 8; i++) begin
      idx = ((i + 1) / SCAN_DIV) % DIGITS;
      exp_seg = seg_model(int'((shown >> (4 * idx)) & 16'h000F));
`ifdef SEG_COUNTER_LZB_EN
      if (idx > 0 && (shown >> (4 * idx)) == 16'h0000) exp_seg = 7'h00;
`endif
      push($sformatf("scan_sel_%0d", i), 32'(4'b0001 << idx));
      push($sformatf("scan_seg_%0d", i), 32'(exp_seg));
    end
    push("scan_bcd", 32'h0042);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      load = 1'b0;
      pop_chk(digit_sel);
      pop_chk(segments);
    end
    pop_chk(bcd_out);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
